// File: rtl/vpu_fp_mul_pipe_pkg.sv
// Shared FP32 field layout, special constants, flag positions and rounding modes
// for the vector FP multiply pipeline.
package vpu_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic {
    RND_RNE = 1'b0,
    RND_RTZ = 1'b1
  } rnd_mode_e;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Subnormals classify as zero: the datapath runs denormals-are-zero.
  function automatic fp_class_e fp_classify(input fp32_t x);
    if (x.expo == '0) return CLS_ZERO;
    if (x.expo != '1) return CLS_NORM;
    if (x.man == '0) return CLS_INF;
    return x.man[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
  endfunction
endpackage

// File: rtl/vpu_fp_mul_pipe_lane.sv
// One FP32 multiply lane: S1 classify, S2 24x24 product, S3 normalise/round/pack.
// Only the S3 output registers are reset; the rest of the datapath is free-running.
module vpu_fp_mul_lane
  import vpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic [31:0] op_0,
  input  logic [31:0] op_1,
  input  logic        en,
  input  rnd_mode_e   rnd_mode,
  output logic [31:0] result,
  output logic [3:0]  flags
);
  fp32_t     a, b;
  fp_class_e cls_a, cls_b;
  logic      sign, sp, sp_nv, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [31:0] sp_res;

  assign a     = op_0;
  assign b     = op_1;
  assign cls_a = fp_classify(a);
  assign cls_b = fp_classify(b);

  always_comb begin
    sign   = a.sign ^ b.sign;
    nan_a  = (cls_a == CLS_QNAN) || (cls_a == CLS_SNAN);
    nan_b  = (cls_b == CLS_QNAN) || (cls_b == CLS_SNAN);
    inf_a  = (cls_a == CLS_INF);
    inf_b  = (cls_b == CLS_INF);
    zero_a = (cls_a == CLS_ZERO);
    zero_b = (cls_b == CLS_ZERO);
    sp     = 1'b1;
    sp_nv  = 1'b0;
    sp_res = '0;
    if (nan_a || nan_b) begin
      sp_res = CANON_NAN;
      sp_nv  = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      sp_res = CANON_NAN;
      sp_nv  = 1'b1;
    end else if (inf_a || inf_b) begin
      sp_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_a || zero_b) begin
      sp_res = {sign, 31'b0};
    end else begin
      sp = 1'b0;
    end
  end

  logic              s1_sign, s1_sp, s1_sp_nv, s1_en;
  logic [31:0]       s1_sp_res;
  logic signed [9:0] s1_exp;
  logic [23:0]       s1_sig_a, s1_sig_b;
  rnd_mode_e         s1_rnd;

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign   <= sign;
      s1_sp     <= sp;
      s1_sp_nv  <= sp_nv;
      s1_sp_res <= sp_res;
      s1_en     <= en;
      s1_rnd    <= rnd_mode;
      s1_exp    <= 10'(a.expo) + 10'(b.expo) - 10'(BIAS);
      s1_sig_a  <= {1'b1, a.man};
      s1_sig_b  <= {1'b1, b.man};
    end
  end

  logic              s2_sign, s2_sp, s2_sp_nv, s2_en;
  logic [31:0]       s2_sp_res;
  logic signed [9:0] s2_exp;
  logic [47:0]       s2_prod;
  rnd_mode_e         s2_rnd;

  always_ff @(posedge clk) begin
    if (adv) begin
      s2_sign   <= s1_sign;
      s2_sp     <= s1_sp;
      s2_sp_nv  <= s1_sp_nv;
      s2_sp_res <= s1_sp_res;
      s2_en     <= s1_en;
      s2_rnd    <= s1_rnd;
      s2_exp    <= s1_exp;
      s2_prod   <= 48'(s1_sig_a) * 48'(s1_sig_b);
    end
  end

  // Product lies in [2^46, 2^48): at most one bit of normalisation.
  logic signed [9:0] norm_exp, exp_r;
  logic [22:0] mant;
  logic [23:0] mant_r;
  logic        guard, sticky, inc;
  logic [31:0] res_n;
  logic [3:0]  flags_n;

  always_comb begin
    norm_exp = s2_prod[47] ? s2_exp + 10'sd1 : s2_exp;
    mant     = s2_prod[47] ? s2_prod[46:24] : s2_prod[45:23];
    guard    = s2_prod[47] ? s2_prod[23] : s2_prod[22];
    sticky   = s2_prod[47] ? |s2_prod[22:0] : |s2_prod[21:0];
    inc      = (s2_rnd == RND_RNE) && guard && (sticky || mant[0]);
    mant_r   = {1'b0, mant} + {23'b0, inc};
    exp_r    = norm_exp + $signed({9'b0, mant_r[23]});
    res_n    = '0;
    flags_n  = '0;
    if (!s2_en) begin
      res_n = '0;
    end else if (s2_sp) begin
      res_n            = s2_sp_res;
      flags_n[FLAG_NV] = s2_sp_nv;
    end else if (norm_exp < 10'sd1) begin
      res_n            = {s2_sign, 31'b0};
      flags_n[FLAG_UF] = 1'b1;
      flags_n[FLAG_NX] = 1'b1;
    end else if (exp_r > 10'sd254) begin
      res_n            = (s2_rnd == RND_RTZ) ? {s2_sign, MAX_FINITE[30:0]}
                                             : {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_n[FLAG_OF] = 1'b1;
      flags_n[FLAG_NX] = 1'b1;
    end else begin
      res_n            = {s2_sign, exp_r[7:0], mant_r[22:0]};
      flags_n[FLAG_NX] = guard || sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
    end else if (adv) begin
      result <= res_n;
      flags  <= flags_n;
    end
  end
endmodule

// File: rtl/vpu_fp_mul_pipe.sv
// Multi-lane FP32 multiplier: 3-stage lockstep pipeline with a single global
// advance; the top owns the valid bits, handshake and flag OR-reduction.
module vpu_fp_mul_pipe
  import vpu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] op_0,
  input  logic [LANES*LANE_W-1:0] op_1,
  input  logic [LANES-1:0]        lane_en,
  input  logic                    rnd_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] result_o,
  output logic [3:0]              flags_o
);
  logic       v1, v2, v3, adv;
  logic [3:0] lane_flags [LANES];

  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;

  // Bubbles travel with the beats; stages never collapse.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vpu_fp_mul_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .op_0     (op_0[i*LANE_W +: LANE_W]),
      .op_1     (op_1[i*LANE_W +: LANE_W]),
      .en       (lane_en[i]),
      .rnd_mode (rnd_mode_e'(rnd_mode)),
      .result   (result_o[i*LANE_W +: LANE_W]),
      .flags    (lane_flags[i])
    );
  end

  always_comb begin
    flags_o = '0;
    for (int i = 0; i < LANES; i++) flags_o = flags_o | lane_flags[i];
  end
endmodule

// File: tb/tb_vpu_fp_mul_pipe.sv
// Scoreboard bench for vpu_fp_mul_pipe: expected beats queued at acceptance,
// observed beats queued by a monitor, compared in order per scenario.
module tb_vpu_fp_mul_pipe;
  localparam int LANES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [127:0]     op_0, op_1, result_o;
  logic [LANES-1:0] lane_en;
  logic             rnd_mode, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]       flags_o;

  typedef struct packed {
    logic [127:0] res;
    logic [3:0]   flags;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    sends_done;

  vpu_fp_mul_pipe #(.LANES(LANES), .LANE_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_0      (op_0),
    .op_1      (op_1),
    .lane_en   (lane_en),
    .rnd_mode  (rnd_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_o  (result_o),
    .flags_o   (flags_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid && out_ready) obs_q.push_back({result_o, flags_o});

  // Reference: integer product, rounding by remainder against half-ulp.
  function automatic logic [35:0] model_lane(input logic [31:0] a, input logic [31:0] b,
                                             input logic rnd);
    logic [7:0] ea, eb;
    logic s, na, nb, sna, snb, ia, ib, za, zb, nx;
    longint unsigned p, kept, rem, half;
    int e, sh;
    ea = a[30:23]; eb = b[30:23];
    s  = a[31] ^ b[31];
    na = (ea == 8'hFF) && (a[22:0] != 0);  nb = (eb == 8'hFF) && (b[22:0] != 0);
    sna = na && !a[22];                     snb = nb && !b[22];
    ia = (ea == 8'hFF) && (a[22:0] == 0);  ib = (eb == 8'hFF) && (b[22:0] == 0);
    za = (ea == 0);                         zb = (eb == 0);
    if (na || nb) return {(sna || snb), 3'b000, 32'h7FC0_0000};
    if ((ia && zb) || (za && ib)) return {4'b1000, 32'h7FC0_0000};
    if (ia || ib) return {4'b0000, s, 31'h7F80_0000};
    if (za || zb) return {4'b0000, s, 31'h0};
    p = (64'(a[22:0]) | 64'h80_0000) * (64'(b[22:0]) | 64'h80_0000);
    e = int'(ea) + int'(eb) - 127;
    sh = 23;
    if (p >= 64'h8000_0000_0000) begin sh = 24; e = e + 1; end
    if (e < 1) return {4'b0011, s, 31'h0};
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = 64'd1 << (sh - 1);
    nx   = (rem != 0);
    if (!rnd && ((rem > half) || ((rem == half) && kept[0]))) kept = kept + 1;
    if (kept == 64'h100_0000) begin kept = 64'h80_0000; e = e + 1; end
    if (e >= 255) return {4'b0101, s, (rnd ? 31'h7F7F_FFFF : 31'h7F80_0000)};
    return {3'b000, nx, s, 8'(e), kept[22:0]};
  endfunction

  function automatic beat_t model_beat(input logic [127:0] a, input logic [127:0] b,
                                       input logic [3:0] en, input logic rnd);
    beat_t r;
    logic [35:0] t;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (en[i]) begin
        t = model_lane(a[i*32 +: 32], b[i*32 +: 32], rnd);
        r.res[i*32 +: 32] = t[31:0];
        r.flags = r.flags | t[35:32];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 19);
    case (k)
      0:       r[30:0] = '0;
      1:       r[30:0] = 31'h7F80_0000;
      2:       r[30:22] = 9'h1FF;
      3:       begin r[30:22] = 9'h1FE; r[0] = 1'b1; end
      4:       r[30:23] = '0;
      5, 6, 7: r[30:23] = 8'($urandom_range(1, 254));
      default: r[30:23] = 8'($urandom_range(96, 158));
    endcase
    return r;
  endfunction

  function automatic logic [127:0] rand_vec();
    logic [127:0] v;
    for (int i = 0; i < LANES; i++) v[i*32 +: 32] = rand_op();
    return v;
  endfunction

  // Called and returns just after a rising edge; leaves in_valid low.
  task automatic send(input logic [127:0] a, input logic [127:0] b, input logic [3:0] en,
                      input logic rnd, input beat_t want);
    bit acc;
    acc = 0;
    op_0 = a; op_1 = b; lane_en = en; rnd_mode = rnd; in_valid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(want);
        acc = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, want 1");
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400 && obs_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (result_o !== '0) begin n_err++; $display("FAIL reset_result: got %h want 0", result_o); end
    n_vec++; if (flags_o !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    beat_t got, want;
    int lat;
    send({4{32'h3F80_0000}}, {4{32'h4000_0000}}, 4'hF, 1'b0, {{4{32'h4000_0000}}, 4'b0000});
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL basic_latency: got %0d cycles want 3", lat); end
    wait_drain();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL basic beat %0d: got res=%h flags=%b want res=%h flags=%b", i, got.res, got.flags, want.res, want.flags); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_specials();
    beat_t got, want;
    send({32'h8000_0000, 32'hFF80_0000, 32'h7FA0_0000, 32'h7F80_0000},
         {32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h0000_0000}, 4'hF, 1'b0,
         {{32'h8000_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000}, 4'b1000});
    send({32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000},
         {32'hBF80_0000, 32'hC000_0000, 32'h0000_0000, 32'h7F80_0000}, 4'hF, 1'b0,
         {{32'h7F80_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h7F80_0000}, 4'b0000});
    wait_drain();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL specials_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL specials beat %0d: got res=%h flags=%b want res=%h flags=%b", i, got.res, got.flags, want.res, want.flags); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow();
    beat_t got, want;
    logic [127:0] a, b;
    a = {32'h3F80_0000, 32'h3F80_0001, 32'hFF00_0000, 32'h7F00_0000};
    b = {32'h3F80_0000, 32'h3F80_0001, 32'h4000_0000, 32'h4000_0000};
    send(a, b, 4'hF, 1'b1, {{32'h3F80_0000, 32'h3F80_0002, 32'hFF7F_FFFF, 32'h7F7F_FFFF}, 4'b0101});
    send(a, b, 4'hF, 1'b0, {{32'h3F80_0000, 32'h3F80_0002, 32'hFF80_0000, 32'h7F80_0000}, 4'b0101});
    wait_drain();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL overflow_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL overflow beat %0d: got res=%h flags=%b want res=%h flags=%b", i, got.res, got.flags, want.res, want.flags); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_underflow();
    beat_t got, want;
    send({32'h3F80_0000, 32'h3F80_0000, 32'h8080_0000, 32'h0080_0000},
         {32'h3F80_0000, 32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000}, 4'hF, 1'b0,
         {{32'h3F80_0000, 32'h3F80_0000, 32'h8000_0000, 32'h0000_0000}, 4'b0011});
    send({32'h3F80_0000, 32'h0040_0000, 32'h807F_FFFF, 32'h0000_0001},
         {32'h3F80_0000, 32'hC000_0000, 32'h3F80_0000, 32'h3F80_0000}, 4'hF, 1'b0,
         {{32'h3F80_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000}, 4'b0000});
    wait_drain();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL underflow_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL underflow beat %0d: got res=%h flags=%b want res=%h flags=%b", i, got.res, got.flags, want.res, want.flags); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_lane_en();
    beat_t got, want;
    send({32'h7F00_0000, 32'h3F80_0000, 32'h7F80_0001, 32'h3F80_0000},
         {32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000}, 4'b0101, 1'b0,
         {{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 32'h4000_0000}, 4'b0000});
    wait_drain();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL lane_en_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL lane_en beat %0d: got res=%h flags=%b want res=%h flags=%b", i, got.res, got.flags, want.res, want.flags); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t got, want;
    logic [127:0] prev_res;
    bit prev_stall;
    prev_stall = 0;
    prev_res = '0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [127:0] a, b;
          logic r;
          a = rand_vec(); b = rand_vec(); r = 1'($urandom_range(0, 1));
          send(a, b, 4'hF, r, model_beat(a, b, 4'hF, r));
        end
      end
      begin
        for (int c = 1; c <= 20; c++) begin
          @(posedge clk); #1;
          out_ready = !(c >= 4 && c <= 7);
        end
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (out_valid && !out_ready) begin
            n_vec++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_in_ready: got %b want 0", in_ready); end
            if (prev_stall) begin
              n_vec++;
              if (result_o !== prev_res) begin n_err++; $display("FAIL b2b_stall_hold: got %h want %h", result_o, prev_res); end
            end
          end
          prev_stall = out_valid && !out_ready;
          prev_res = result_o;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL b2b beat %0d: got res=%h flags=%b want res=%h flags=%b", i, got.res, got.flags, want.res, want.flags); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    beat_t got, want;
    sends_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [127:0] a, b;
          logic [3:0] en;
          logic r;
          a = rand_vec(); b = rand_vec();
          en = 4'($urandom_range(0, 15)); r = 1'($urandom_range(0, 1));
          send(a, b, en, r, model_beat(a, b, en, r));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        sends_done = 1;
      end
      begin
        while (!sends_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      want = exp_q.pop_front(); got = obs_q.pop_front(); n_vec++;
      if (got !== want) begin n_err++; $display("FAIL random beat %0d: got res=%h flags=%b want res=%h flags=%b", i, got.res, got.flags, want.res, want.flags); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    out_ready = 1'b1;
    send({4{32'h3F80_0000}}, {4{32'h4040_0000}}, 4'hF, 1'b0, '0);
    send({4{32'h4000_0000}}, {4{32'h4040_0000}}, 4'hF, 1'b0, '0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    if (out_valid) seen++;
    repeat (8) begin @(negedge clk); if (out_valid) seen++; end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL rst_mid_out_valid: got %0d valid cycles want 0", seen); end
    n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rst_mid_stale: got %0d outputs want 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_0 = '0; op_1 = '0; lane_en = '0; rnd_mode = 1'b0;
    test_reset();
    test_basic();
    test_specials();
    test_overflow();
    test_underflow();
    test_lane_en();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2 ms, want finished");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/vpu_fp_mul_pipe.md
VPU_FP_MUL_PIPE -- requirements
Module: vpu_fp_mul_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent FP32 lanes (1..16).
REQ-002 SHALL have parameter LANE_W, default 32: lane width in bits; only 32 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports op_0 and op_1, input, LANES*LANE_W bits each: packed operands; lane i occupies bits [i*32 +: 32].
REQ-006 SHALL have port lane_en, input, LANES bits: per-lane enable, sampled with the operands.
REQ-007 SHALL have port rnd_mode, input, 1 bit: 0 = round-to-nearest-even (RNE), 1 = round-toward-zero (RTZ); sampled with the operands.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-010 SHALL have port result_o, output, LANES*LANE_W bits: packed products.
REQ-011 SHALL have port flags_o, output, 4 bits: {NV, OF, UF, NX}, each OR-reduced over enabled lanes of the same beat.

Function
REQ-012 SHALL implement a 3-stage pipeline: S1 unpack/classify, S2 significand product, S3 normalise/round/pack.
REQ-013 SHALL give a latency of exactly 3 cycles from an accepted input beat to out_valid, with no stall.
REQ-014 SHALL compute adv = !v3 | out_ready; in_ready SHALL equal adv; all stages SHALL shift together when adv=1 and hold when adv=0.
REQ-015 SHALL accept a beat only when in_valid & in_ready; out_valid SHALL equal v3; result_o and flags_o SHALL be stable while out_valid & !out_ready.
REQ-016 SHALL not collapse bubbles; beats SHALL leave in acceptance order, with no loss or duplication.
REQ-017 SHALL give each lane sign = s0^s1.
REQ-018 SHALL treat subnormal inputs as zero of the same sign (DAZ).
REQ-019 SHALL output 0x7FC00000 for any NaN input; NV SHALL be set only for sNaN inputs or for inf*0, which also yields 0x7FC00000.
REQ-020 SHALL output signed inf for inf*finite-nonzero or inf*inf, with no flags.
REQ-021 SHALL output signed zero for zero*finite, with no flags.
REQ-022 SHALL form the product from a 24x24 significand multiply, normalise by at most 1 bit, and round with guard/sticky per rnd_mode; NX SHALL be set if any discarded bit is nonzero.
REQ-023 SHALL handle overflow (biased exponent >= 255 after rounding) by setting OF and NX; the result SHALL be signed inf under RNE and signed 0x7F7FFFFF under RTZ.
REQ-024 SHALL handle underflow (result below min normal before rounding) by flushing to signed zero (FTZ) and setting UF and NX.
REQ-025 SHALL output 0x00000000 on a disabled lane, and that lane SHALL contribute no flags.
REQ-026 SHALL carry rnd_mode and lane_en through the pipeline with their beat; a change between beats SHALL not affect in-flight beats.

Reset
REQ-027 SHALL clear v1..v3 while rst=1; out_valid SHALL be 0, result_o 0 and flags_o 0.
REQ-028 SHALL discard all in-flight beats when rst is asserted mid-operation; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 SHALL not reset datapath registers other than the valid bits and the output registers.

Structure
REQ-030 SHALL place FP32 field widths (EXP_W=8, MAN_W=23, BIAS=127), the canonical NaN, the max-finite constant, the flag bit indices and a rounding-mode enum in VPU_PKG.
REQ-031 SHALL instantiate sub-module vpu_fp_mul_lane LANES times; it SHALL hold the per-lane S1-S3 datapath with stage enable adv, while the top holds the valid/handshake logic and the flag reduction.

Verification
REQ-032 SHALL cover: LANES=4, all lanes 0x3F800000*0x40000000, RNE, out_ready=1 -> result 0x40000000 per lane on cycle 3, flags 0.
REQ-033 SHALL cover: 10 back-to-back beats, out_ready held 0 for cycles 4-7 -> in_ready=0 during the stall, all 10 results in order, none lost or duplicated.
REQ-034 SHALL cover: lane0 0x7F800000*0x00000000, lane1 0x7FA00000*0x3F800000 -> both 0x7FC00000, flags NV=1.
REQ-035 SHALL cover: 0x7F000000*0x40000000 under RTZ -> 0x7F7FFFFF, OF=NX=1; under RNE -> 0x7F800000.
REQ-036 SHALL cover: 0x00800000*0x3F000000 -> 0x00000000, UF=NX=1; a subnormal input -> signed zero.
REQ-037 SHALL cover: lane_en=4'b0101 -> lanes 1 and 3 read 0x00000000; rst pulsed with 2 beats in flight -> out_valid stays 0 and no stale output appears.
